// File: rtl/gnrc_codec_pkg.sv
// ----------------------------------------------------------------------------
// gnrc_codec_pkg
//   Shared helpers for the generic codec library.
//   - cnt_width(n): bits needed to hold a count in 0..n (at least 1).
//   Payload structs depend on the instance width N. A package cannot be
//   parameterised, so each block declares its own payload typedefs from N.
// ----------------------------------------------------------------------------
package gnrc_codec_pkg;

    // Width of a counter that must represent every value 0..n inclusive.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/gnrc_therm2bin.sv
// ----------------------------------------------------------------------------
// gnrc_therm2bin
//   Combinational thermometer-to-binary converter.
//   The input is a low-justified thermometer code (ones from bit 0 upward,
//   then zeros). The output is the number of ones, 0..N.
//
// Ports
//   therm_i  in   N    thermometer code, ones packed at the LSB end
//   cnt_o    out  CW   number of ones in therm_i
//
// A one-hot edge detect marks the top one of the thermometer. Each one-hot
// position i contributes the constant (i+1) through an OR tree, so an all-zero
// thermometer gives a count of 0 without an adder.
// ----------------------------------------------------------------------------
module gnrc_therm2bin
    import gnrc_codec_pkg::*;
#(
    parameter  int unsigned N  = 8,
    localparam int unsigned CW = cnt_width(N)
) (
    input  logic [N-1:0]  therm_i,
    output logic [CW-1:0] cnt_o
);

    logic [N-1:0] edge_oh;

    // Only the highest set bit of a well-formed thermometer survives.
    assign edge_oh = therm_i & ~(therm_i >> 1);

    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < N; i++) begin
            if (edge_oh[i]) cnt_o = cnt_o | CW'(i + 1);
        end
    end

endmodule

// File: rtl/gnrc_tz_norm.sv
// ----------------------------------------------------------------------------
// gnrc_tz_norm
//   Two-stage pipelined LSB-aligned normaliser. Counts the zeros below the
//   lowest set bit of vec_i and shifts the vector right so that bit lands on
//   bit 0. Valid/ready on both sides, one beat per cycle, two-cycle latency.
//
// Ports
//   clk_i    in   1    clock, rising edge
//   rst_ni   in   1    synchronous active-low reset
//   flush_i  in   1    drop everything in flight (and this cycle's input)
//   valid_i  in   1    input beat valid
//   ready_o  out  1    block can take an input beat
//   vec_i    in   N    input vector
//   valid_o  out  1    output beat valid
//   ready_i  in   1    consumer takes the output beat
//   norm_o   out  N    vec >> cnt, zero filled from the MSB
//   cnt_o    out  CW   zeros below the lowest set bit, N for vec == 0
//   zero_o   out  1    vec == 0
//
// Stage 1 captures vec and its thermometer code therm[i] = ~|vec[i:0].
// Stage 2 converts the thermometer to a count, barrel-shifts vec by it and
// captures the result. Each stage holds its data while it cannot move on.
// ----------------------------------------------------------------------------
module gnrc_tz_norm
    import gnrc_codec_pkg::*;
#(
    parameter  int unsigned N  = 8,
    localparam int unsigned CW = cnt_width(N)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    input  logic          valid_i,
    output logic          ready_o,
    input  logic [N-1:0]  vec_i,
    output logic          valid_o,
    input  logic          ready_i,
    output logic [N-1:0]  norm_o,
    output logic [CW-1:0] cnt_o,
    output logic          zero_o
);

    typedef struct packed {
        logic [N-1:0] vec;
        logic [N-1:0] therm;
    } s1_pld_t;

    typedef struct packed {
        logic [N-1:0]  norm;
        logic [CW-1:0] cnt;
        logic          zero;
    } s2_pld_t;

    logic    s1_valid_q, s1_valid_d;
    logic    s2_valid_q, s2_valid_d;
    s1_pld_t s1_q, s1_d;
    s2_pld_t s2_q, s2_d;

    logic    s2_adv;
    logic    s1_load;
    logic    s2_load;
    logic [N-1:0]  therm;
    logic [CW-1:0] s2_cnt;

    // ------------------------------------------------------------------
    // Handshake. ready_o never looks at valid_i, so no comb loop can form
    // through an upstream block that gates valid on ready.
    // ------------------------------------------------------------------
    assign s2_adv  = ~s2_valid_q | ready_i;
    assign ready_o = ~s1_valid_q | s2_adv;

    // A flush discards the beat offered in the same cycle; blocking the
    // data loads as well keeps the registers quiet for that edge.
    assign s1_load = valid_i & ready_o & ~flush_i;
    assign s2_load = s1_valid_q & s2_adv & ~flush_i;

    always_comb begin
        s1_valid_d = s1_valid_q;
        if (flush_i)      s1_valid_d = 1'b0;
        else if (s1_load) s1_valid_d = 1'b1;
        else if (s2_load) s1_valid_d = 1'b0;
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        if (flush_i)      s2_valid_d = 1'b0;
        else if (s2_load) s2_valid_d = 1'b1;
        else if (ready_i) s2_valid_d = 1'b0;
    end

    // ------------------------------------------------------------------
    // Stage 1: prefix-AND of the inverted vector from bit 0 upward.
    // A running scalar keeps the chain free of self-referencing vectors.
    // ------------------------------------------------------------------
    always_comb begin
        logic run;
        run   = 1'b1;
        therm = '0;
        for (int i = 0; i < N; i++) begin
            run      = run & ~vec_i[i];
            therm[i] = run;
        end
    end

    assign s1_d.vec   = vec_i;
    assign s1_d.therm = therm;

    // ------------------------------------------------------------------
    // Stage 2: count, shift, zero flag.
    // ------------------------------------------------------------------
    gnrc_therm2bin #(
        .N (N)
    ) u_therm2bin (
        .therm_i (s1_q.therm),
        .cnt_o   (s2_cnt)
    );

    // Log2 barrel shifter, one stage per count bit. The top stage can shift
    // by N or more, which correctly empties the vector when vec == 0.
    always_comb begin
        logic [N-1:0] sh;
        sh = s1_q.vec;
        for (int s = 0; s < CW; s++) begin
            if (s2_cnt[s]) sh = sh >> (1 << s);
        end
        s2_d.norm = sh;
        s2_d.cnt  = s2_cnt;
        // The top thermometer bit is set exactly when no bit of vec is set.
        s2_d.zero = s1_q.therm[N-1];
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_q       <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            if (s1_load) s1_q <= s1_d;
            if (s2_load) s2_q <= s2_d;
        end
    end

    assign valid_o = s2_valid_q;
    assign norm_o  = s2_q.norm;
    assign cnt_o   = s2_q.cnt;
    assign zero_o  = s2_q.zero;

`ifndef SYNTHESIS
    // A presented output beat stays put until it is taken.
    a_out_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (valid_o && !ready_i && !flush_i) |=>
            (valid_o && $stable(norm_o) && $stable(cnt_o) && $stable(zero_o)));

    // The count never exceeds the vector width.
    a_cnt_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        valid_o |-> (int'(cnt_o) <= int'(N)));
`endif

endmodule

// File: tb/tb_gnrc_tz_norm.sv
module tb_gnrc_tz_norm;

    logic       clk = 1'b0;
    logic       rst_n, flush, valid_i, ready_i, ready_o, valid_o, zero_o;
    logic [7:0] vec_i, norm_o;
    logic [3:0] cnt_o;

    // N=1 build
    logic       flush1 = 1'b0;
    logic       v1_valid_i, v1_ready_o, v1_valid_o, v1_ready_i, v1_zero;
    logic [0:0] v1_vec, v1_norm, v1_cnt;

    always #5 clk = ~clk;

    gnrc_tz_norm #(.N(8)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .valid_i(valid_i), .ready_o(ready_o), .vec_i(vec_i),
        .valid_o(valid_o), .ready_i(ready_i),
        .norm_o(norm_o), .cnt_o(cnt_o), .zero_o(zero_o)
    );

    gnrc_tz_norm #(.N(1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush1),
        .valid_i(v1_valid_i), .ready_o(v1_ready_o), .vec_i(v1_vec),
        .valid_o(v1_valid_o), .ready_i(v1_ready_i),
        .norm_o(v1_norm), .cnt_o(v1_cnt), .zero_o(v1_zero)
    );

    typedef struct {
        logic [7:0] norm;
        logic [3:0] cnt;
        logic       zero;
        int         cyc;
    } exp_t;

    typedef struct {
        logic [7:0] vec;
        logic [7:0] norm;
        logic [3:0] cnt;
        logic       zero;
    } tv_t;

    exp_t        sb[$];
    tv_t         tbl[4];
    int          nvec = 0, nerr = 0, cyc = 0;
    int          n_in = 0, n_out = 0;
    bit          stall_prev = 0, chk_lat = 0, use_tbl = 0, last_in_fire = 0;
    logic [12:0] prev_out = '0;
    exp_t        tbl_exp;
    int          exp_rdy = -1, exp_vld = -1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [7:0] v);
        exp_t e;
        e.cnt = 4'd8;
        for (int i = 7; i >= 0; i--) if (v[i]) e.cnt = 4'(i);
        e.norm = v >> e.cnt;
        e.zero = (v == 8'h00);
        e.cyc  = 0;
        return e;
    endfunction

    // One clock: handshake accounting and checks at the negedge, then the
    // active edge, then return 1 time unit later so the caller can drive.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (exp_rdy >= 0) begin chk("ready_o", 32'(ready_o), 32'(exp_rdy)); exp_rdy = -1; end
        if (exp_vld >= 0) begin chk("valid_o", 32'(valid_o), 32'(exp_vld)); exp_vld = -1; end
        last_in_fire = 0;
        if (!rst_n || flush) begin
            sb.delete();
            stall_prev = 0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", 32'(valid_o), 32'd1);
                chk("hold_data", 32'({norm_o, cnt_o, zero_o}), 32'(prev_out));
            end
            if (valid_o && ready_i) begin
                n_out++;
                chk("beat_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("norm", 32'(norm_o), 32'(e.norm));
                    chk("cnt", 32'(cnt_o), 32'(e.cnt));
                    chk("zero", 32'(zero_o), 32'(e.zero));
                    if (chk_lat) chk("latency", 32'(cyc - e.cyc), 32'd2);
                end
            end
            stall_prev = valid_o && !ready_i;
            prev_out   = {norm_o, cnt_o, zero_o};
            if (valid_i && ready_o) begin
                n_in++;
                last_in_fire = 1;
                if (use_tbl) e = tbl_exp;
                else         e = model(vec_i);
                e.cyc = cyc;
                sb.push_back(e);
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic drain(input int max_cyc);
        valid_i = 1'b0;
        ready_i = 1'b1;
        for (int k = 0; k < max_cyc && sb.size() != 0; k++) step();
        step();
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    function automatic logic [7:0] rand_vec();
        int unsigned sel;
        sel = $urandom_range(0, 7);
        if (sel == 0)      return 8'h00;
        else if (sel <= 2) return 8'h01 << $urandom_range(0, 7);
        else               return 8'($urandom);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n_in0, n_out0;
        tbl[0] = '{8'h28, 8'h05, 4'd3, 1'b0};
        tbl[1] = '{8'h80, 8'h01, 4'd7, 1'b0};
        tbl[2] = '{8'h01, 8'h01, 4'd0, 1'b0};
        tbl[3] = '{8'h00, 8'h00, 4'd8, 1'b1};

        rst_n = 1'b0; flush = 1'b0; valid_i = 1'b1; vec_i = 8'hAA; ready_i = 1'b1;
        v1_valid_i = 1'b0; v1_vec = 1'b0; v1_ready_i = 1'b1;

        // Reset with a beat offered
        step(); step();
        chk("rst_valid_o", 32'(valid_o), 32'd0);
        chk("rst_ready_o", 32'(ready_o), 32'd1);
        chk("rst_norm_o", 32'(norm_o), 32'd0);
        chk("rst_cnt_o", 32'(cnt_o), 32'd0);
        chk("rst_zero_o", 32'(zero_o), 32'd0);
        chk("rst_v1_valid_o", 32'(v1_valid_o), 32'd0);

        // First beat after release: 0xAA -> cnt 1, norm 0x55
        rst_n = 1'b1; chk_lat = 1; use_tbl = 1;
        tbl_exp = '{8'h55, 4'd1, 1'b0, 0};
        step();
        drain(10);

        // Back-to-back table stream
        for (int i = 0; i < 4; i++) begin
            vec_i   = tbl[i].vec;
            tbl_exp = '{tbl[i].norm, tbl[i].cnt, tbl[i].zero, 0};
            valid_i = 1'b1;
            step();
        end
        drain(10);
        use_tbl = 0; chk_lat = 0;

        // Consumer stall for 5 cycles, 3 beats offered
        ready_i = 1'b0; valid_i = 1'b1;
        vec_i = 8'h14; step();
        vec_i = 8'h03; step();
        vec_i = 8'h40;
        for (int k = 0; k < 3; k++) begin exp_rdy = 0; step(); end
        ready_i = 1'b1;
        step();
        drain(10);

        // Flush with full pipeline and a beat offered
        ready_i = 1'b0; valid_i = 1'b1;
        vec_i = 8'h22; step();
        vec_i = 8'h09; step();
        flush = 1'b1; vec_i = 8'h3C; step();
        flush = 1'b0; valid_i = 1'b0;
        exp_vld = 0; exp_rdy = 1;
        step();
        n_out0 = n_out;
        ready_i = 1'b1;
        repeat (4) step();
        chk("flush_no_out", 32'(n_out - n_out0), 32'd0);

        // Reset while stalled
        ready_i = 1'b0; valid_i = 1'b1;
        vec_i = 8'h11; step();
        vec_i = 8'h06; step();
        valid_i = 1'b0; step();
        rst_n = 1'b0; step();
        rst_n = 1'b1; exp_vld = 0; exp_rdy = 1;
        step();
        chk("rst2_cnt_o", 32'(cnt_o), 32'd0);
        chk("rst2_norm_o", 32'(norm_o), 32'd0);

        // Random valid/ready against the model
        n_in0 = n_in; n_out0 = n_out;
        valid_i = 1'b0;
        for (int k = 0; k < 40000 && (n_in - n_in0) < 10000; k++) begin
            if (!(valid_i && !last_in_fire)) begin
                valid_i = ($urandom_range(0, 9) < 7);
                vec_i   = rand_vec();
            end
            ready_i = ($urandom_range(0, 9) < 6);
            step();
        end
        drain(20);
        chk("rand_beats_in", 32'((n_in - n_in0) >= 10000), 32'd1);
        chk("rand_in_eq_out", 32'(n_out - n_out0), 32'(n_in - n_in0));

        // N=1 build: 1 -> cnt 0 norm 1; 0 -> cnt 1 zero 1
        v1_ready_i = 1'b1; v1_valid_i = 1'b1; v1_vec = 1'b1;
        step();
        v1_vec = 1'b0;
        step();
        v1_valid_i = 1'b0;
        chk("n1_a_valid", 32'(v1_valid_o), 32'd1);
        chk("n1_a_cnt", 32'(v1_cnt), 32'd0);
        chk("n1_a_norm", 32'(v1_norm), 32'd1);
        chk("n1_a_zero", 32'(v1_zero), 32'd0);
        step();
        chk("n1_b_valid", 32'(v1_valid_o), 32'd1);
        chk("n1_b_cnt", 32'(v1_cnt), 32'd1);
        chk("n1_b_norm", 32'(v1_norm), 32'd0);
        chk("n1_b_zero", 32'(v1_zero), 32'd1);
        step();
        chk("n1_empty", 32'(v1_valid_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
